pio_led_fader: RTL and testbench

//  Downstream consumer of the 4-bit PIO output register (out_port) that drives the board LEDs.
//  - Turns each pattern bit into a PWM LED drive whose brightness ramps linearly up (bit=1) or down (bit=0).
//  - Software writes on/off; this block supplies the fade.
//  - Single clock domain, same clock as the PIO slave.

---
 rtl/pio_led_fader.sv | 105 ++++++++++
 tb/tb_pio_led_fader.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pio_led_fader.sv
// rtl/pio_led_fader.sv - fades PIO LED pattern bits into linearly ramping PWM drives
// Build option: LED_FADER_ACTIVE_LOW_EN inverts led_out for active-low LEDs.
module pio_led_fader #(
  parameter int NUM_CH   = 4,
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] pattern_in,
  output logic [NUM_CH-1:0] led_out,
  output logic              busy
);
  localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] MAX      = '1;
  localparam logic [PWM_BITS-1:0] MAX_M1   = MAX - 1'b1;
  localparam logic [PWM_BITS-1:0] ONE      = PWM_BITS'(1);

  typedef enum logic [1:0] {OFF = 2'd0, UP = 2'd1, ON = 2'd2, DOWN = 2'd3} state_t;

  logic [NUM_CH-1:0]                pattern_q;
  logic [PRE_W-1:0]                 pre_cnt;
  logic [PWM_BITS-1:0]              pwm_cnt;
  logic [NUM_CH-1:0][PWM_BITS-1:0]  level;
  state_t                           state [NUM_CH];
  state_t                           nxt   [NUM_CH];
  logic [NUM_CH-1:0]                active;
  logic [NUM_CH-1:0]                raw;
  logic                             tick;

  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern_q <= '0;
      pre_cnt   <= '0;
      pwm_cnt   <= '0;
    end else begin
      pattern_q <= pattern_in;
      pre_cnt   <= tick ? '0 : pre_cnt + 1'b1;
      pwm_cnt   <= (pwm_cnt == MAX_M1) ? '0 : pwm_cnt + 1'b1;
    end
  end

  // Direction follows the captured pattern bit; reversals keep the current level.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      nxt[i] = state[i];
      case (state[i])
        OFF:     if (pattern_q[i])  nxt[i] = UP;
        UP:      if (!pattern_q[i]) nxt[i] = DOWN;
        ON:      if (!pattern_q[i]) nxt[i] = DOWN;
        default: if (pattern_q[i])  nxt[i] = UP;
      endcase
      active[i] = (state[i] == UP) || (state[i] == DOWN);
    end
  end

  // A tick steps in the new direction; reaching either end settles into ON/OFF.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state[i] <= OFF;
        level[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state[i] <= nxt[i];
        if (tick && nxt[i] == UP) begin
          if (level[i] >= MAX_M1) begin
            level[i] <= MAX;
            state[i] <= ON;
          end else begin
            level[i] <= level[i] + 1'b1;
          end
        end else if (tick && nxt[i] == DOWN) begin
          if (level[i] <= ONE) begin
            level[i] <= '0;
            state[i] <= OFF;
          end else begin
            level[i] <= level[i] - 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      raw  <= '0;
      busy <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) raw[i] <= (level[i] > pwm_cnt);
      busy <= |active;
    end
  end

`ifdef LED_FADER_ACTIVE_LOW_EN
  assign led_out = ~raw;
`else
  assign led_out = raw;
`endif

endmodule

// File: tb/tb_pio_led_fader.sv
// tb/tb_pio_led_fader.sv - directed self-checking bench for pio_led_fader
module tb_pio_led_fader;
  localparam int NUM_CH   = 4;
  localparam int PWM_BITS = 4;
  localparam int STEP_DIV = 4;
`ifdef LED_FADER_ACTIVE_LOW_EN
  localparam logic [3:0] DARK = 4'hF;
`else
  localparam logic [3:0] DARK = 4'h0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] pattern_in = 4'h0;
  logic [3:0] pattern2 = 4'h0;
  logic [3:0] led_out, led2;
  logic       busy, busy2;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  pio_led_fader #(.NUM_CH(NUM_CH), .PWM_BITS(PWM_BITS), .STEP_DIV(STEP_DIV)) dut (
    .clk(clk), .reset_n(reset_n), .pattern_in(pattern_in), .led_out(led_out), .busy(busy)
  );

  // Slow-stepping copy so a level holds still long enough to measure duty.
  pio_led_fader #(.NUM_CH(NUM_CH), .PWM_BITS(PWM_BITS), .STEP_DIV(256)) dut2 (
    .clk(clk), .reset_n(reset_n), .pattern_in(pattern2), .led_out(led2), .busy(busy2)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int t, t1, t15, tprev, prev, cur, hi, others, maxl;
    bit found;

    // Reset with all pattern bits high
    reset_n = 1'b0;
    pattern_in = 4'hF;
    clocks(3);
    check("rst_led", led_out, DARK);
    check("rst_busy", busy, 0);
    check("rst_level", dut.level[0], 0);
    reset_n = 1'b1;
    clocks(1);
    check("rel_busy_e1", busy, 0);
    clocks(2);
    check("rel_busy_e3", busy, 1);
    clocks(1);
    check("rel_level3_e4", dut.level[3], 1);

    // Full ramp on ch0 only
    reset_n = 1'b0;
    pattern_in = 4'h0;
    clocks(2);
    reset_n = 1'b1;
    clocks(4);
    check("idle_busy", busy, 0);
    check("idle_led", led_out, DARK);
    pattern_in = 4'h1;
    t = 0; t1 = -1; t15 = -1; tprev = 0; prev = 0; others = 0;
    while (t < 80 && t15 < 0) begin
      clocks(1);
      t++;
      cur = dut.level[0];
      if (((led_out ^ DARK) & 4'hE) != 0) others++;
      if (cur != prev) begin
        check("ramp_inc", cur, prev + 1);
        if (cur == 1) t1 = t;
        else check("ramp_gap", t - tprev, 4);
        tprev = t;
        prev = cur;
        if (cur == 15) t15 = t;
      end
    end
    check("ramp_first_in_window", (t1 >= 3 && t1 <= 6) ? 1 : 0, 1);
    check("ramp_full_in_window", (t15 >= 59 && t15 <= 62) ? 1 : 0, 1);
    check("ramp_others_dark", others, 0);
    clocks(2);
    check("ramp_busy_fall", busy, 0);
    hi = 0; others = 0;
    for (int k = 0; k < 15; k++) begin
      clocks(1);
      if (((led_out ^ DARK) & 4'h1) != 0) hi++;
      if (((led_out ^ DARK) & 4'hE) != 0) others++;
    end
    check("max_led0_on", hi, 15);
    check("max_others_dark", others, 0);

    // Duty at level 5 on the slow instance
    pattern2 = 4'h1;
    found = 1'b0;
    for (int k = 0; k < 3000 && !found; k++) begin
      clocks(1);
      if (dut2.level[0] == 4'd5) found = 1'b1;
    end
    check("duty_reach5", found, 1);
    clocks(2);
    hi = 0;
    for (int k = 0; k < 30; k++) begin
      clocks(1);
      if (((led2 ^ DARK) & 4'h1) != 0) hi++;
    end
    check("duty_5_of_15", hi, 10);
    pattern2 = 4'h0;

    // Reversal at level 7
    reset_n = 1'b0;
    pattern_in = 4'h0;
    clocks(2);
    reset_n = 1'b1;
    clocks(2);
    pattern_in = 4'h1;
    found = 1'b0;
    for (int k = 0; k < 80 && !found; k++) begin
      clocks(1);
      if (dut.level[0] == 4'd7) found = 1'b1;
    end
    check("rev_reach7", found, 1);
    pattern_in = 4'h0;
    clocks(3);
    check("rev_hold7", dut.level[0], 7);
    clocks(1);
    check("rev_first_down", dut.level[0], 6);
    maxl = 6;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      clocks(1);
      cur = dut.level[0];
      if (cur > maxl) maxl = cur;
      if (cur == 0) found = 1'b1;
    end
    check("rev_reach0", found, 1);
    check("rev_never_above7", (maxl <= 7) ? 1 : 0, 1);
    clocks(2);
    check("rev_busy_off", busy, 0);
    check("rev_state_off", dut.state[0], 0);

    // Reset pulse mid-ramp at level 9
    pattern_in = 4'h1;
    found = 1'b0;
    for (int k = 0; k < 80 && !found; k++) begin
      clocks(1);
      if (dut.level[0] == 4'd9) found = 1'b1;
    end
    check("mid_reach9", found, 1);
    reset_n = 1'b0;
    #1;
    check("mid_led_async", led_out, DARK);
    check("mid_busy_async", busy, 0);
    check("mid_level_async", dut.level[0], 0);
    @(negedge clk);
    reset_n = 1'b1;
    clocks(3);
    check("mid_level_hold0", dut.level[0], 0);
    check("mid_busy_restart", busy, 1);
    clocks(1);
    check("mid_level_restart1", dut.level[0], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
